// File: rtl/stack_frame_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | stack_frame_ctrl_pkg                                                       |
// | Command, error, SuperStack op/status codes and FSM states for the          |
// | call-frame sequencer.                                                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package stack_frame_ctrl_pkg;

   // SuperStack op codes
   localparam logic [2:0] OP_NONE                 = 3'd0;
   localparam logic [2:0] OP_PUSH                 = 3'd1;
   localparam logic [2:0] OP_POP                  = 3'd2;
   localparam logic [2:0] OP_INDEX_RESET          = 3'd3;
   localparam logic [2:0] OP_INDEX_RESET_AND_PUSH = 3'd4;
   localparam logic [2:0] OP_UNDERFLOW_GET        = 3'd5;
   localparam logic [2:0] OP_UNDERFLOW_SET        = 3'd6;

   // SuperStack status codes
   localparam logic [2:0] ST_OK         = 3'd0;
   localparam logic [2:0] ST_EMPTY      = 3'd1;
   localparam logic [2:0] ST_FULL       = 3'd2;
   localparam logic [2:0] ST_OVERFLOW   = 3'd3;
   localparam logic [2:0] ST_UNDERFLOW  = 3'd4;
   localparam logic [2:0] ST_BAD_OFFSET = 3'd5;

   // Request commands
   localparam logic [2:0] SFC_CALL   = 3'd1;
   localparam logic [2:0] SFC_RETURN = 3'd2;
   localparam logic [2:0] SFC_LGET   = 3'd3;
   localparam logic [2:0] SFC_LSET   = 3'd4;
   localparam logic [2:0] SFC_LTEE   = 3'd5;

   // Response codes
   localparam logic [2:0] SFC_OK         = 3'd0;
   localparam logic [2:0] SFC_FRAME_OVF  = 3'd1;
   localparam logic [2:0] SFC_FRAME_UNF  = 3'd2;
   localparam logic [2:0] SFC_STACK_ERR  = 3'd3;
   localparam logic [2:0] SFC_RESULT_ERR = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_CHECK  = 3'd2,
      S_ISSUE2 = 3'd3,
      S_CHECK2 = 3'd4,
      S_RESP   = 3'd5
   } sfc_state_t;

   function automatic logic is_stack_fault(input logic [2:0] status);
      return (status == ST_OVERFLOW) || (status == ST_UNDERFLOW) || (status == ST_BAD_OFFSET);
   endfunction

endpackage

`default_nettype wire

// File: rtl/stack_frame_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | stack_frame_ctrl_if                                                        |
// | Request/response handshake plus the SuperStack op bus of the sequencer.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface stack_frame_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 7
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_cmd;
   logic [DEPTH:0]   req_arg;
   logic [DEPTH:0]   req_locals;
   logic             rsp_valid;
   logic [2:0]       rsp_err;

   logic [2:0]       st_op;
   logic [WIDTH-1:0] st_data;
   logic [DEPTH:0]   st_offset;
   logic [DEPTH:0]   st_underflow;
   logic [DEPTH:0]   st_upper;
   logic [DEPTH:0]   st_lower;
   logic             st_dropTos;
   logic [DEPTH:0]   st_index;
   logic [WIDTH-1:0] st_out;
   logic [2:0]       st_status;

   // master: requester and SuperStack side; slave: the sequencer
   modport master (
      output req_valid, req_cmd, req_arg, req_locals,
      output st_index, st_out, st_status,
      input  req_ready, rsp_valid, rsp_err,
      input  st_op, st_data, st_offset, st_underflow, st_upper, st_lower, st_dropTos
   );

   modport slave (
      input  req_valid, req_cmd, req_arg, req_locals,
      input  st_index, st_out, st_status,
      output req_ready, rsp_valid, rsp_err,
      output st_op, st_data, st_offset, st_underflow, st_upper, st_lower, st_dropTos
   );

endinterface

`default_nettype wire

// File: rtl/stack_frame_ctrl_frame_mem.sv
// +----------------------------------------------------------------------------+
// | stack_frame_ctrl_frame_mem                                                 |
// | LIFO of saved caller windows with push/pop/full/empty and live top entry.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stack_frame_ctrl_frame_mem #(
   parameter int FDEPTH = 4,
   parameter int DW     = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DW-1:0]     push_data,
   output logic [DW-1:0]     top_data,
   output logic              full,
   output logic              empty,
   output logic [FDEPTH:0]   count
);
   localparam int ENTRIES = 2**FDEPTH;

   logic [DW-1:0]     r_mem [ENTRIES];
   logic [FDEPTH:0]   r_count;
   logic [FDEPTH-1:0] w_top_idx;

   // Low bits wrap to the last slot when the LIFO is full
   assign w_top_idx = r_count[FDEPTH-1:0] - (FDEPTH)'(1);
   assign top_data  = r_mem[w_top_idx];
   assign full      = r_count[FDEPTH];
   assign empty     = (r_count == '0);
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (push && !full) begin
         r_count <= r_count + (FDEPTH+1)'(1);
      end else if (pop && !empty) begin
         r_count <= r_count - (FDEPTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         r_mem[r_count[FDEPTH-1:0]] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stack_frame_ctrl.sv
// +----------------------------------------------------------------------------+
// | stack_frame_ctrl                                                           |
// | Call-frame sequencer in front of SuperStack; owns the frame window.        |
// | Optional macro SFC_RESULT_CHECK_EN: RETURN verifies the result count.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stack_frame_ctrl
   import stack_frame_ctrl_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 7,
   parameter int FDEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   stack_frame_ctrl_if.slave bus,
   output logic [FDEPTH:0]   call_depth
);
   localparam int FW = 3*(DEPTH+1);

   sfc_state_t       r_state;
   sfc_state_t       w_next;

   logic [DEPTH:0]   r_lower;
   logic [DEPTH:0]   r_upper;
   logic [DEPTH:0]   r_underflow;
   logic [DEPTH:0]   r_arg;
   logic [DEPTH:0]   r_new_lower;
   logic [DEPTH:0]   r_new_top;
   logic [2:0]       r_cmd;
   logic [2:0]       r_err;
   logic [WIDTH-1:0] r_tos;
   logic [WIDTH-1:0] r_data;

   logic [DEPTH:0]   w_new_lower;
   logic [DEPTH:0]   w_new_top;
   logic [2:0]       w_early_err;
   logic             w_fault;
   logic             w_fm_push;
   logic             w_fm_pop;
   logic             w_fm_full;
   logic             w_fm_empty;
   logic [FW-1:0]    w_fm_top;

   assign w_new_lower = bus.st_index - bus.req_arg;
   assign w_new_top   = w_new_lower + bus.req_arg + bus.req_locals;
   assign w_fault     = is_stack_fault(bus.st_status);

`ifdef SFC_RESULT_CHECK_EN
   logic [DEPTH:0] w_ret_r;
   assign w_ret_r = {{DEPTH{1'b0}}, (bus.req_arg != '0)};
`endif

   // Errors decided at accept time skip the stack entirely
   always_comb begin
      w_early_err = SFC_OK;
      case (bus.req_cmd)
         SFC_CALL: begin
            if (w_fm_full) w_early_err = SFC_FRAME_OVF;
         end
         SFC_RETURN: begin
            if (w_fm_empty) w_early_err = SFC_FRAME_UNF;
`ifdef SFC_RESULT_CHECK_EN
            else if ((bus.st_index - w_ret_r) != r_upper) w_early_err = SFC_RESULT_ERR;
`endif
         end
         SFC_LGET, SFC_LSET, SFC_LTEE: w_early_err = SFC_OK;
         default: w_early_err = SFC_STACK_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      w_fm_push       = 1'b0;
      w_fm_pop        = 1'b0;
      bus.st_op       = OP_NONE;
      bus.st_data     = '0;
      bus.st_offset   = '0;
      bus.st_dropTos  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) w_next = (w_early_err != SFC_OK) ? S_RESP : S_ISSUE;
         end
         S_ISSUE: begin
            w_next = S_CHECK;
            case (r_cmd)
               SFC_CALL: begin
                  bus.st_op     = OP_INDEX_RESET;
                  bus.st_offset = r_new_top;
                  w_fm_push     = 1'b1;
               end
               SFC_RETURN: begin
                  bus.st_op     = (r_arg != '0) ? OP_INDEX_RESET_AND_PUSH : OP_INDEX_RESET;
                  bus.st_offset = r_lower;
                  bus.st_data   = r_tos;
               end
               SFC_LGET: begin
                  bus.st_op     = OP_UNDERFLOW_GET;
                  bus.st_offset = r_arg;
               end
               default: begin
                  bus.st_op      = OP_UNDERFLOW_SET;
                  bus.st_offset  = r_arg;
                  bus.st_data    = r_tos;
                  bus.st_dropTos = (r_cmd == SFC_LSET);
               end
            endcase
         end
         S_CHECK: begin
            if (w_fault) begin
               w_next   = S_RESP;
               w_fm_pop = (r_cmd == SFC_CALL);
            end else begin
               w_next   = (r_cmd == SFC_LGET) ? S_ISSUE2 : S_RESP;
               w_fm_pop = (r_cmd == SFC_RETURN);
            end
         end
         S_ISSUE2: begin
            w_next      = S_CHECK2;
            bus.st_op   = OP_PUSH;
            bus.st_data = r_data;
         end
         S_CHECK2: w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lower     <= '0;
         r_upper     <= '0;
         r_underflow <= '0;
         r_arg       <= '0;
         r_new_lower <= '0;
         r_new_top   <= '0;
         r_cmd       <= '0;
         r_err       <= SFC_OK;
         r_tos       <= '0;
         r_data      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_cmd       <= bus.req_cmd;
                  r_arg       <= bus.req_arg;
                  r_new_lower <= w_new_lower;
                  r_new_top   <= w_new_top;
                  r_tos       <= bus.st_out;
                  r_err       <= w_early_err;
               end
            end
            S_CHECK: begin
               if (w_fault) begin
                  r_err <= SFC_STACK_ERR;
               end else if (r_cmd == SFC_CALL) begin
                  r_lower     <= r_new_lower;
                  r_upper     <= r_new_top;
                  r_underflow <= r_new_top;
               end else if (r_cmd == SFC_RETURN) begin
                  {r_lower, r_upper, r_underflow} <= w_fm_top;
               end
               r_data <= bus.st_out;
            end
            S_CHECK2: begin
               if (w_fault) r_err <= SFC_STACK_ERR;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready    = (r_state == S_IDLE);
   assign bus.rsp_valid    = (r_state == S_RESP);
   assign bus.rsp_err      = r_err;
   assign bus.st_lower     = r_lower;
   assign bus.st_upper     = r_upper;
   assign bus.st_underflow = r_underflow;

   stack_frame_ctrl_frame_mem #(
      .FDEPTH (FDEPTH),
      .DW     (FW)
   ) u_frame_mem (
      .clk       (clk),
      .reset     (reset),
      .push      (w_fm_push),
      .pop       (w_fm_pop),
      .push_data ({r_lower, r_upper, r_underflow}),
      .top_data  (w_fm_top),
      .full      (w_fm_full),
      .empty     (w_fm_empty),
      .count     (call_depth)
   );

endmodule

`default_nettype wire

// File: tb/tb_stack_frame_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_stack_frame_ctrl                                                        |
// | Directed bench with a behavioural SuperStack model driving the stack bus.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stack_frame_ctrl;
   import stack_frame_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       m_rst = 1'b1;
   logic [4:0] call_depth;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stack_frame_ctrl_if #(.WIDTH(8), .DEPTH(7)) bus ();

   stack_frame_ctrl #(.WIDTH(8), .DEPTH(7), .FDEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .call_depth (call_depth)
   );

   // Behavioural SuperStack: index = number of live entries, ToS at index-1
   logic [7:0] m_mem [256];
   logic [7:0] m_idx, m_out, m_addr;
   logic [2:0] m_status;
   logic       tb_push_en = 1'b0;
   logic [7:0] tb_push_data = '0;
   int         push_cnt;

   assign bus.st_index  = m_idx;
   assign bus.st_out    = m_out;
   assign bus.st_status = m_status;

   always @(posedge clk) begin
      if (m_rst) begin
         m_idx <= '0; m_out <= '0; m_status <= ST_OK; push_cnt <= 0;
         for (int i = 0; i < 256; i++) m_mem[i] <= '0;
      end else if (tb_push_en) begin
         m_mem[m_idx] <= tb_push_data; m_idx <= m_idx + 8'd1; m_out <= tb_push_data;
      end else begin
         m_status <= ST_OK;
         m_addr = bus.st_lower + bus.st_offset;
         case (bus.st_op)
            OP_PUSH: begin
               push_cnt <= push_cnt + 1;
               if (m_idx == 8'hFF) m_status <= ST_OVERFLOW;
               else begin
                  m_mem[m_idx] <= bus.st_data; m_idx <= m_idx + 8'd1; m_out <= bus.st_data;
               end
            end
            OP_INDEX_RESET: begin
               for (int i = 0; i < 256; i++)
                  if (i >= int'(m_idx) && i < int'(bus.st_offset)) m_mem[i] <= '0;
               m_idx <= bus.st_offset;
               m_out <= (bus.st_offset > m_idx || bus.st_offset == 8'd0) ? 8'd0 : m_mem[bus.st_offset - 8'd1];
            end
            OP_INDEX_RESET_AND_PUSH: begin
               m_mem[bus.st_offset] <= bus.st_data;
               m_idx <= bus.st_offset + 8'd1;
               m_out <= bus.st_data;
            end
            OP_UNDERFLOW_GET: begin
               if (bus.st_offset >= (bus.st_upper - bus.st_lower)) m_status <= ST_BAD_OFFSET;
               else m_out <= m_mem[m_addr];
            end
            OP_UNDERFLOW_SET: begin
               if (bus.st_offset >= (bus.st_upper - bus.st_lower)) m_status <= ST_BAD_OFFSET;
               else begin
                  m_mem[m_addr] <= bus.st_data;
                  if (bus.st_dropTos) begin
                     m_idx <= m_idx - 8'd1;
                     m_out <= (m_addr == m_idx - 8'd2) ? bus.st_data : m_mem[m_idx - 8'd2];
                  end else begin
                     m_out <= (m_addr == m_idx - 8'd1) ? bus.st_data : m_mem[m_idx - 8'd1];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tb_push(input logic [7:0] v);
      @(negedge clk);
      tb_push_en = 1'b1; tb_push_data = v;
      @(negedge clk);
      tb_push_en = 1'b0;
   endtask

   // Latency counts the accept cycle as cycle 1
   task automatic do_req(input logic [2:0] cmd, input logic [7:0] arg, input logic [7:0] loc,
                         output logic [2:0] err, output int lat);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_arg = arg; bus.req_locals = loc;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 2;
      while (!bus.rsp_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      err = bus.rsp_err;
   endtask

   logic [2:0] err;
   int         lat;
   int         pc0;

   initial begin
      bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_arg = '0; bus.req_locals = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0; m_rst = 1'b0;

      // Reset state
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, SFC_OK);
      chk("rst_op", bus.st_op, OP_NONE);
      chk("rst_drop", bus.st_dropTos, 0);
      chk("rst_limits", {bus.st_lower, bus.st_upper, bus.st_underflow}, 0);
      chk("rst_depth", call_depth, 0);

      // Test 1: three values then CALL P=2 L=1
      tb_push(8'h11); tb_push(8'h22); tb_push(8'h33);
      do_req(SFC_CALL, 8'd2, 8'd1, err, lat);
      chk("call_err", err, SFC_OK);
      chk("call_lat", lat, 4);
      chk("call_lower", bus.st_lower, 1);
      chk("call_upper", bus.st_upper, 4);
      chk("call_uflow", bus.st_underflow, 4);
      chk("call_index", m_idx, 4);
      chk("call_newslot", m_mem[3], 0);
      chk("call_depth1", call_depth, 1);

      // Test 2: LOCAL_GET inside and outside the frame
      do_req(SFC_LGET, 8'd1, 8'd0, err, lat);
      chk("lget_err", err, SFC_OK);
      chk("lget_lat", lat, 6);
      chk("lget_tos", m_out, 8'h33);
      chk("lget_index", m_idx, 5);
      do_req(SFC_LGET, 8'd3, 8'd0, err, lat);
      chk("lget_bad_err", err, SFC_STACK_ERR);
      chk("lget_bad_index", m_idx, 5);

      // Test 3: LOCAL_SET / LOCAL_TEE
      tb_push(8'h5A);
      do_req(SFC_LSET, 8'd2, 8'd0, err, lat);
      chk("lset_err", err, SFC_OK);
      chk("lset_slot", m_mem[3], 8'h5A);
      chk("lset_index", m_idx, 5);
      do_req(SFC_LTEE, 8'd0, 8'd0, err, lat);
      chk("ltee_err", err, SFC_OK);
      chk("ltee_slot", m_mem[1], 8'h33);
      chk("ltee_index", m_idx, 5);
      do_req(SFC_LSET, 8'd1, 8'd0, err, lat);
      chk("lset2_slot", m_mem[2], 8'h33);
      chk("lset2_index", m_idx, 4);

      // Test 4: RETURN R=1
      tb_push(8'h77);
      do_req(SFC_RETURN, 8'd1, 8'd0, err, lat);
      chk("ret_err", err, SFC_OK);
      chk("ret_lat", lat, 4);
      chk("ret_index", m_idx, 2);
      chk("ret_tos", m_out, 8'h77);
      chk("ret_limits", {bus.st_lower, bus.st_upper, bus.st_underflow}, 0);
      chk("ret_depth", call_depth, 0);

      // Test 5: underflow, nesting to the limit, overflow, bad command
      do_req(SFC_RETURN, 8'd0, 8'd0, err, lat);
      chk("ret_unf_err", err, SFC_FRAME_UNF);
      chk("ret_unf_lat", lat, 2);
      for (int k = 0; k < 16; k++) begin
         do_req(SFC_CALL, 8'd0, 8'd0, err, lat);
         chk("nest_err", err, SFC_OK);
      end
      chk("nest_depth", call_depth, 16);
      do_req(SFC_CALL, 8'd0, 8'd0, err, lat);
      chk("ovf_err", err, SFC_FRAME_OVF);
      chk("ovf_lat", lat, 2);
      chk("ovf_depth", call_depth, 16);
      chk("ovf_index", m_idx, 2);
      pc0 = push_cnt;
      do_req(3'd7, 8'd0, 8'd0, err, lat);
      chk("badcmd_err", err, SFC_STACK_ERR);
      chk("badcmd_lat", lat, 2);
      chk("badcmd_index", m_idx, 2);

      // Test 6: reset in the middle of a LOCAL_GET
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("rst2_depth", call_depth, 0);
      do_req(SFC_CALL, 8'd0, 8'd2, err, lat);
      chk("call2_err", err, SFC_OK);
      chk("call2_lower", bus.st_lower, 2);
      chk("call2_index", m_idx, 4);
      pc0 = push_cnt;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_cmd = SFC_LGET; bus.req_arg = 8'd0; bus.req_locals = 8'd0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("mid_issue_op", bus.st_op, OP_UNDERFLOW_GET);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_ready", bus.req_ready, 1);
      chk("mid_limits", {bus.st_lower, bus.st_upper, bus.st_underflow}, 0);
      chk("mid_depth", call_depth, 0);
      repeat (4) @(negedge clk);
      chk("mid_no_push", push_cnt, pc0);
      chk("mid_index", m_idx, 4);
      chk("mid_rsp", bus.rsp_valid, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
